// File: rtl/slow_gate.sv
// Slow-mode gate: forces motherboard-synchronous slow mode during accesses to slow peripherals.
// Define SLOW_HOLD_EN to build the post-access hold timer (HOLD state and tick counter).
module slow_gate #(
  parameter int TICKW = 4
) (
  input  logic       CLK,
  input  logic       POR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  input  logic       Tick,
  output logic       Slow,
  output logic       ClockGate,
  output logic       Holding
);

  localparam logic [1:0] FAST = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;

  logic [1:0] state;
  logic [1:0] nextState;
  logic       hit;
  logic       holdNext;

  assign hit = BACT & |{IACKCS & SlowIACK, VIACS & SlowVIA, IWMCS & SlowIWM,
                        SCCCS & SlowSCC, SCSICS & SlowSCSI, SndCS & SlowSnd};

`ifdef SLOW_HOLD_EN
  localparam logic [1:0]         HOLD    = 2'd2;
  localparam logic [3+TICKW:0]   CNT_ONE = {{(3+TICKW){1'b0}}, 1'b1};

  logic [3+TICKW:0] cnt;
  logic [3+TICKW:0] cntNext;

  always_comb begin
    nextState = state;
    cntNext   = cnt;
    case (state)
      FAST: if (hit) nextState = ACC;
      ACC: begin
        // The reload wins over any Tick seen on the same edge.
        if (!BACT) begin
          cntNext   = {SlowTimeout, {TICKW{1'b1}}};
          nextState = (SlowTimeout == 4'd0) ? FAST : HOLD;
        end
      end
      HOLD: begin
        if (hit) begin
          nextState = ACC;
        end else if (Tick && cnt != '0) begin
          cntNext = cnt - CNT_ONE;
          if (cnt == CNT_ONE) nextState = FAST;
        end
      end
      default: nextState = FAST;
    endcase
  end

  assign holdNext = (nextState == HOLD);

  always_ff @(posedge CLK) begin
    if (POR) cnt <= '0;
    else     cnt <= cntNext;
  end
`else
  logic             unusedHoldInputs;
  logic [TICKW-1:0] unusedTickPad;

  assign unusedHoldInputs = ^{SlowTimeout, Tick};
  assign unusedTickPad    = '0;

  always_comb begin
    nextState = state;
    case (state)
      FAST:    if (hit) nextState = ACC;
      ACC:     if (!BACT) nextState = FAST;
      default: nextState = FAST;
    endcase
  end

  assign holdNext = 1'b0;
`endif

  // Outputs are registered from the next state so Slow rises on the edge that samples the hit.
  always_ff @(posedge CLK) begin
    if (POR) begin
      state     <= FAST;
      Slow      <= 1'b0;
      ClockGate <= 1'b0;
      Holding   <= 1'b0;
    end else begin
      state     <= nextState;
      Slow      <= (nextState != FAST);
      ClockGate <= Slow & SlowClockGate;
      Holding   <= holdNext;
    end
  end

endmodule

// File: tb/tb_slow_gate.sv
// Bench for slow_gate: directed scenarios plus random traffic against a hold-time reference model.
// Model honours SLOW_HOLD_EN the same way the design does.
module tb_slow_gate;

  localparam int TICKW = 4;
`ifdef SLOW_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       POR;
  logic       BACT;
  logic [5:0] cs;   // IACK, VIA, IWM, SCC, SCSI, Snd
  logic [5:0] en;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       Tick;
  logic       Slow;
  logic       ClockGate;
  logic       Holding;

  slow_gate #(.TICKW(TICKW)) dut (
    .CLK(CLK), .POR(POR), .BACT(BACT),
    .IACKCS(cs[0]), .VIACS(cs[1]), .IWMCS(cs[2]), .SCCCS(cs[3]), .SCSICS(cs[4]), .SndCS(cs[5]),
    .SlowIACK(en[0]), .SlowVIA(en[1]), .SlowIWM(en[2]), .SlowSCC(en[3]), .SlowSCSI(en[4]), .SlowSnd(en[5]),
    .SlowClockGate(SlowClockGate), .SlowTimeout(SlowTimeout), .Tick(Tick),
    .Slow(Slow), .ClockGate(ClockGate), .Holding(Holding)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: "in a slow access" flag plus the number of Ticks still owed after it.
  bit mInAccess = 1'b0;
  int mTicksLeft = 0;
  bit mSlow = 1'b0, mCg = 1'b0, mHolding = 1'b0;

  task automatic modelStep();
    bit prevSlow;
    bit hit;
    prevSlow = mSlow;
    hit = BACT && ((cs & en) != 6'd0);
    if (POR) begin
      mInAccess = 1'b0; mTicksLeft = 0;
      mSlow = 1'b0; mCg = 1'b0; mHolding = 1'b0;
    end else begin
      if (mInAccess) begin
        if (!BACT) begin
          mInAccess = 1'b0;
          mTicksLeft = HOLD_EN ? int'(SlowTimeout) * (2 ** TICKW) + (2 ** TICKW - 1) : 0;
          if (SlowTimeout == 4'd0) mTicksLeft = 0;
        end
      end else if (hit) begin
        mInAccess = 1'b1;
        mTicksLeft = 0;
      end else if (mTicksLeft > 0 && Tick) begin
        mTicksLeft--;
      end
      mSlow = mInAccess || (mTicksLeft > 0);
      mHolding = !mInAccess && (mTicksLeft > 0);
      mCg = prevSlow && SlowClockGate;
    end
  endtask

  task automatic step();
    modelStep();
    @(posedge CLK);
    #1;
    check("Slow", Slow, mSlow);
    check("ClockGate", ClockGate, mCg);
    check("Holding", Holding, mHolding);
  endtask

  // Counts consecutive Slow cycles from the current step until Slow drops; Tick toggles if requested.
  task automatic countHold(input bit toggleTick, output int n);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (!Slow) break;
      n++;
      if (toggleTick) Tick = ~Tick;
    end
  endtask

  initial begin
    int n;
    int accLeft;
    POR = 1'b1; BACT = 1'b1; cs = 6'b000010; en = 6'b000010;
    SlowClockGate = 1'b1; SlowTimeout = 4'd0; Tick = 1'b1;

    // Reset held with hit stimulus present
    for (int i = 0; i < 3; i++) step();
    check("resetSlow", Slow, 0);
    check("resetHolding", Holding, 0);
    POR = 1'b0; BACT = 1'b0; cs = '0; SlowClockGate = 1'b0; Tick = 1'b0;
    step(); step();
    check("afterResetFast", Slow, 0);

    // VIA access, no hold
    n = 0;
    BACT = 1'b1; cs = 6'b000010;
    for (int i = 0; i < 4; i++) begin step(); n += int'(Slow); end
    BACT = 1'b0; cs = '0;
    for (int i = 0; i < 4; i++) begin step(); n += int'(Slow); end
    check("viaSlowLen", n, 4);

    // IWM access, SlowTimeout=1, Tick every second cycle
    en = 6'b000100; SlowTimeout = 4'd1;
    BACT = 1'b1; cs = 6'b000100;
    for (int i = 0; i < 3; i++) step();
    BACT = 1'b0; cs = '0; Tick = 1'b1;
    countHold(1'b1, n);
    check("iwmHoldCycles", n, HOLD_EN ? 62 : 0);
    Tick = 1'b0;
    step(); step();

    // Re-hit in HOLD with five Ticks left; must fully reload
    en = 6'b001100;
    BACT = 1'b1; cs = 6'b000100;
    for (int i = 0; i < 2; i++) step();
    BACT = 1'b0; cs = '0; Tick = 1'b0;
    step();
    Tick = 1'b1;
    for (int i = 0; i < 26; i++) step();
    check("holdingBeforeRehit", Holding, HOLD_EN ? 1 : 0);
    BACT = 1'b1; cs = 6'b001000;
    step();
    check("rehitLeavesHold", Holding, 0);
    check("rehitSlow", Slow, 1);
    step(); step();
    BACT = 1'b0; cs = '0;
    countHold(1'b0, n);
    check("reloadHoldCycles", n, HOLD_EN ? 31 : 0);
    Tick = 1'b0;

    // SCSI not marked slow
    en = 6'b101111; n = 0;
    BACT = 1'b1; cs = 6'b010000;
    for (int i = 0; i < 3; i++) begin step(); n += int'(Slow); end
    BACT = 1'b0; cs = '0;
    step();
    check("scsiNotSlow", n, 0);

    // Clock gating follows Slow by one cycle
    en = 6'b111111; SlowTimeout = 4'd0; SlowClockGate = 1'b1; n = 0;
    BACT = 1'b1; cs = 6'b100000;
    for (int i = 0; i < 4; i++) begin step(); n += int'(ClockGate); end
    check("cgLagsSlow", ClockGate, 0 + 32'(n >= 3));
    BACT = 1'b0; cs = '0;
    for (int i = 0; i < 3; i++) begin step(); n += int'(ClockGate); end
    check("cgCycles", n, 4);
    SlowClockGate = 1'b0;

    // POR in the middle of a hold
    SlowTimeout = 4'd2;
    BACT = 1'b1; cs = 6'b000001;
    step(); step();
    BACT = 1'b0; cs = '0; Tick = 1'b1;
    for (int i = 0; i < 5; i++) step();
    POR = 1'b1;
    step();
    check("porSlow", Slow, 0);
    check("porHolding", Holding, 0);
    POR = 1'b0; n = 0;
    for (int i = 0; i < 10; i++) begin step(); n += int'(Slow); end
    check("noResidualHold", n, 0);

    // SlowTimeout=F: drops at once only without the hold feature
    SlowTimeout = 4'hF; Tick = 1'b0;
    BACT = 1'b1; cs = 6'b000010;
    for (int i = 0; i < 3; i++) step();
    BACT = 1'b0; cs = '0;
    step();
    check("stFAfterAccess", Slow, HOLD_EN ? 1 : 0);
    POR = 1'b1; step(); POR = 1'b0; step();

    // Random traffic
    accLeft = 0; SlowTimeout = 4'd1;
    for (int i = 0; i < 3000; i++) begin
      POR = ($urandom_range(0, 299) == 0);
      if (accLeft > 0) accLeft--;
      else if ($urandom_range(0, 5) == 0) accLeft = $urandom_range(1, 6);
      BACT = (accLeft > 0);
      cs = 6'($urandom_range(0, 63));
      Tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0)
        SlowTimeout = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) en = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 15) == 0) SlowClockGate = ~SlowClockGate;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/slow_gate.md
# slow_gate

Consumes the speed-control bits produced by the slow-device configuration register and decides cycle by cycle whether the accelerator must fall back to motherboard-synchronous slow mode. Any bus access to a peripheral whose Slow bit is set forces slow mode for the duration of the access. After the access, slow mode is held for a programmable number of prescaler ticks derived from `SlowTimeout`. The block sits between the address decoder and config register on one side and the clock/bus-cycle sequencer on the other.

## Interface
Parameters:
- `TICKW`, 4: width of the low (fixed all-ones) part of the hold counter; the hold counter is `4+TICKW` bits.

Ports:
- `CLK` in 1: system clock.
- `POR` in 1: synchronous, active-high reset.
- `BACT` in 1: CPU bus access active.
- `IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS` in 1 each: decoded selects; valid while `BACT`=1.
- `SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd` in 1 each: per-device slow enables from the config register.
- `SlowClockGate` in 1: clock-gating enable from the config register.
- `SlowTimeout` in 4: hold length, high nibble of the hold counter.
- `Tick` in 1: one-`CLK` prescaler strobe.
- `Slow` out 1: registered; slow mode is required.
- `ClockGate` out 1: registered; equals `Slow && SlowClockGate`, delayed one cycle.
- `Holding` out 1: registered; 1 while in HOLD.

## Operation
- Hit: `Hit = |{IACKCS&SlowIACK, VIACS&SlowVIA, IWMCS&SlowIWM, SCCCS&SlowSCC, SCSICS&SlowSCSI, SndCS&SlowSnd}`, qualified by `BACT`.
- FSM states: FAST, ACC, HOLD.
- FAST:
  - `BACT && Hit` -> ACC.
  - Otherwise stay in FAST.
- ACC:
  - Stay while `BACT`=1.
  - On `BACT`=0, load `Cnt <= {SlowTimeout, {TICKW{1'b1}}}`.
  - If `SlowTimeout`=0, go to FAST.
  - Otherwise go to HOLD.
- HOLD:
  - `BACT && Hit` -> ACC; the counter is reloaded again when that access ends.
  - Otherwise, on `Tick`, `Cnt <= Cnt-1`.
  - `Cnt`=1 with `Tick` -> FAST.
  - Non-hit accesses during HOLD do not reset the counter.
- Load beats decrement in the same cycle. `Cnt` never wraps below 0.
- `SlowTimeout` is sampled only at load. A config write during HOLD takes effect on the next load.
- `Slow` = 1 in ACC and HOLD, 0 in FAST.
- `Holding` = 1 in HOLD only.
- `POR`: state -> FAST; `Cnt`, `Slow`, `ClockGate`, `Holding` -> 0. This applies mid-access or mid-hold, with no residual hold.

## Timing
- `BACT && Hit` sampled at edge N -> `Slow`=1 after edge N. Latency is 1 `CLK`.
- `BACT` falls (sampled 0 at edge M) in ACC:
  - `SlowTimeout`=0 -> `Slow`=0 after edge M.
  - `SlowTimeout`≠0 -> `Slow` stays 1.
- Hold duration is exactly `SlowTimeout*2^TICKW + (2^TICKW-1)` `Tick` pulses. `Slow` drops on the edge that samples the final `Tick`.
- `ClockGate` lags `Slow` by exactly 1 `CLK`.
- `Tick` arriving in the same cycle as the HOLD -> ACC transition is ignored.

## Configuration
- Macro: `SLOW_HOLD_EN`.
- Defined: full behaviour as above.
- Undefined:
  - HOLD state and `Cnt` are not built; `SlowTimeout` and `Tick` are ignored.
  - ACC -> FAST on `BACT`=0.
  - `Holding` is tied to 0.
  - `Slow` tracks hit accesses only, still with 1-cycle latency.

## Test plan
- Reset: hold `POR`=1 for 3 cycles with hit stimulus -> `Slow`, `ClockGate`, `Holding` = 0. Release -> FAST.
- `SlowVIA`=1, `SlowTimeout`=0, 4-cycle VIA access -> `Slow`=1 for exactly 4 cycles, starting 1 cycle after `BACT` rises. `Holding` stays 0.
- `TICKW`=4, `SlowTimeout`=1, `Tick` every 2nd cycle, IWM access -> `Slow` held for 31 `Tick`s (62 cycles) after `BACT` falls, then 0.
- In HOLD with `Cnt`=5, new SCC hit access -> ACC. At the access end `Cnt` = `{SlowTimeout,4'hF}` (full reload). A `Tick` coincident with the reload does not decrement.
- `SlowSCSI`=0 with SCSI access -> `Slow` stays 0. Hit access with `SlowClockGate`=1 -> `ClockGate` follows `Slow` one cycle later.
- `POR` asserted mid-HOLD -> all outputs 0 on the next cycle. With `SLOW_HOLD_EN` undefined, `SlowTimeout`=F access -> `Slow` drops 1 cycle after `BACT` falls.
